// File: rtl/aes_rb_pkg.sv
// Shared types and helpers for the redundant-byte AES datapath.
`ifndef RB_D
`define RB_D 2
`endif

package aes_rb_pkg;

  localparam int unsigned D        = `RB_D;
  localparam int unsigned NB_BYTES = 16;

  // Redundant byte: 8 data bits followed by D redundancy bits, bit 0 is MSB
  typedef logic [0:7+D] rb_byte_t;

  // Full AES state indexed [row][column]
  typedef rb_byte_t [3:0][3:0] rb_state_t;

  // Per-bank occupancy in the ping-pong buffers
  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_st_e;

  // Source index for column-major output position k after inverse ShiftRows:
  // row r = k mod 4, column c = k div 4, source column (c - r) mod 4
  function automatic logic [3:0] inv_sr_src(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = k[1:0];
    c  = k[3:2];
    sc = c - r;
    return {sc, r};
  endfunction

endpackage

// File: rtl/inv_sr_bank.sv
// 16-entry byte bank: indexed write, combinational permuted read.
module inv_sr_bank
  import aes_rb_pkg::*;
#(
  parameter int unsigned W = 8 + D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [3:0]   i_wr_idx,
  input  logic [0:W-1] i_wr_data,
  input  logic [3:0]   i_rd_idx,
  output logic [0:W-1] o_rd_data
);

  logic [0:W-1] r_mem [NB_BYTES];

  // Storage: cleared on reset, one entry written per accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NB_BYTES; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Read side applies the inverse row rotation through the address
  assign o_rd_data = r_mem[inv_sr_src(i_rd_idx)];

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial inverse ShiftRows with a ping-pong double buffer.
module inv_shift_rows_stream
  import aes_rb_pkg::*;
#(
  parameter int unsigned d = D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:7+d] in_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:7+d] out_byte,
  output logic         out_last
);

  localparam int unsigned W = 8 + d;

  bank_st_e     r_st [2];
  logic         r_wr_bank;
  logic [3:0]   r_wr_cnt;
  logic         r_rd_bank;
  logic [3:0]   r_rd_cnt;

  bank_st_e     w_st_nxt [2];
  logic         w_in_acc;
  logic         w_out_acc;
  logic [0:W-1] w_rd0;
  logic [0:W-1] w_rd1;

  assign in_ready  = (r_st[r_wr_bank] == BANK_EMPTY) && !clr;
  assign out_valid = (r_st[r_rd_bank] == BANK_FULL);
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready && !clr;
  assign out_byte  = r_rd_bank ? w_rd1 : w_rd0;
  assign out_last  = out_valid && (r_rd_cnt == 4'hF);

  inv_sr_bank #(.W(W)) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_in_acc && !r_wr_bank),
    .i_wr_idx  (r_wr_cnt),
    .i_wr_data (in_byte),
    .i_rd_idx  (r_rd_cnt),
    .o_rd_data (w_rd0)
  );

  inv_sr_bank #(.W(W)) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_in_acc && r_wr_bank),
    .i_wr_idx  (r_wr_cnt),
    .i_wr_data (in_byte),
    .i_rd_idx  (r_rd_cnt),
    .o_rd_data (w_rd1)
  );

  // Bank status next-state: fill and drain may complete on different banks in one cycle
  always_comb begin
    w_st_nxt = r_st;
    if (w_in_acc && (r_wr_cnt == 4'hF)) begin
      w_st_nxt[r_wr_bank] = BANK_FULL;
    end
    if (w_out_acc && (r_rd_cnt == 4'hF)) begin
      w_st_nxt[r_rd_bank] = BANK_EMPTY;
    end
  end

  // Handshake counters, bank pointers and status; clr mirrors reset except storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st[0]   <= BANK_EMPTY;
      r_st[1]   <= BANK_EMPTY;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else if (clr) begin
      r_st[0]   <= BANK_EMPTY;
      r_st[1]   <= BANK_EMPTY;
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_in_acc) begin
        r_wr_cnt <= r_wr_cnt + 4'd1;
        if (r_wr_cnt == 4'hF) begin
          r_wr_bank <= !r_wr_bank;
        end
      end
      if (w_out_acc) begin
        r_rd_cnt <= r_rd_cnt + 4'd1;
        if (r_rd_cnt == 4'hF) begin
          r_rd_bank <= !r_rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Scoreboard bench for inv_shift_rows_stream with a block-level reference model.
module tb_inv_shift_rows_stream;
  import aes_rb_pkg::*;

  localparam int unsigned DW = 8 + D;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [0:DW-1] in_byte;
  logic          out_valid;
  logic          out_ready;
  logic [0:DW-1] out_byte;
  logic          out_last;

  always #5 clk = ~clk;

  inv_shift_rows_stream #(.d(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: collect a block, then emit it in inverse-shifted order
  logic [0:DW-1] mdl_blk [16];
  int            mdl_wr = 0;
  logic [0:DW-1] q_byte [$];
  logic          q_last [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_accept(input logic [0:DW-1] b);
    int r;
    int c;
    int s;
    mdl_blk[mdl_wr] = b;
    mdl_wr++;
    if (mdl_wr == 16) begin
      for (int k = 0; k < 16; k++) begin
        r = k % 4;
        c = k / 4;
        s = 4 * ((c - r + 4) % 4) + r;
        q_byte.push_back(mdl_blk[s]);
        q_last.push_back(k == 15);
      end
      mdl_wr = 0;
    end
  endfunction

  function automatic void model_flush();
    q_byte.delete();
    q_last.delete();
    mdl_wr = 0;
  endfunction

  // Monitor: compare whenever output is presented, pop on a completed handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (out_valid) begin
          if (q_byte.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got byte %0h with empty scoreboard", out_byte);
          end else begin
            chk("out_byte", 32'(out_byte), 32'(q_byte[0]));
            chk("out_last", 32'(out_last), 32'(q_last[0]));
            if (out_ready && !clr) begin
              void'(q_byte.pop_front());
              void'(q_last.pop_front());
            end
          end
        end else begin
          chk("last_idle", 32'(out_last), 32'd0);
        end
      end
    end
  end

  // Offer one byte until accepted (bounded); returns aligned #1 after the accept edge
  task automatic send(input logic [0:DW-1] b, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(b);
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          total++;
          bad++;
          $display("FAIL send_timeout: in_ready stuck 0, expected 1");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q_byte.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 32'(q_byte.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int            st;
    int            st_sum;
    int            acc;
    logic [0:DW-1] b;
    logic [0:DW-1] mask;

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_byte   = '0;
    out_ready = 1'b1;
    mask      = DW'((1 << D) - 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_byte", 32'(out_byte), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Counting block: known permutation and first-output latency
    for (int k = 0; k < 15; k++) begin
      b = DW'(k) << D;
      send(b, st);
    end
    chk("no_early_valid", 32'(out_valid), 32'd0);
    b = DW'(15) << D;
    send(b, st);
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("first_byte", 32'(out_byte), 32'd0);
    in_valid = 1'b0;
    wait_drain();

    // Four back-to-back random blocks
    st_sum = 0;
    for (int i = 0; i < 64; i++) begin
      b = DW'($urandom);
      send(b, st);
      st_sum += st;
    end
    chk("b2b_stalls", 32'(st_sum), 32'd0);
    chk("b2b_backlog", 32'(q_byte.size()), 32'd16);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: both banks fill, then drain in order
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      b = DW'($urandom);
      in_byte = b;
      @(negedge clk);
      if (in_ready) begin
        model_accept(b);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'd32);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_drain();
    chk("bp_recover_ready", 32'(in_ready), 32'd1);

    // Redundancy bits all ones must survive the permutation
    for (int k = 0; k < 16; k++) begin
      b = (DW'(k) << D) | mask;
      send(b, st);
    end
    chk("redund_bits", 32'(out_byte & mask), 32'(mask));
    in_valid = 1'b0;
    wait_drain();

    // Flush a partial block with clr, then a fresh block
    for (int i = 0; i < 7; i++) begin
      b = DW'($urandom);
      send(b, st);
    end
    in_valid = 1'b1;
    in_byte  = DW'($urandom);
    clr      = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    mdl_wr   = 0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      b = DW'($urandom);
      send(b, st);
    end
    in_valid = 1'b0;
    wait_drain();

    // Asynchronous reset part-way through draining a block
    for (int i = 0; i < 16; i++) begin
      b = DW'($urandom);
      send(b, st);
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_left", 32'(q_byte.size()), 32'd11);
    rst_n = 1'b0;
    #1;
    chk("rst_valid_drop", 32'(out_valid), 32'd0);
    chk("rst_in_ready2", 32'(in_ready), 32'd1);
    model_flush();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      b = DW'($urandom);
      send(b, st);
    end
    in_valid = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_stream.md
Name: inv_shift_rows_stream

Overview:
- Byte-serial inverse ShiftRows stage for the decryption datapath of the full redundant-byte AES core.
- Accepts one 16-byte block of redundant bytes (8+d bits each) in column-major order over a valid/ready stream.
- Emits the block in column-major order after the inverse row rotation: out[r][c] = in[r][(c-r) mod 4].
- Ping-pong double buffer sustains one byte per cycle on both sides. This is the sequential counterpart of the forward combinational row shift and sits between the serial key-add and the inverse S-box lanes.

Parameters:
- d, default `d (global define), number of redundancy bits per byte; element width is 8+d, indexed [0:7+d], bit 0 is MSB.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush; discards both banks and both counters
- in_valid  in  1  input byte valid
- in_ready  out  1  stage can accept a byte
- in_byte  in  8+d  redundant byte; stream index k = 4*col + row
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts a byte
- out_byte  out  8+d  shifted byte; stream index k = 4*col + row
- out_last  out  1  high with the 16th byte of a block (k=15)

Behaviour:
- Storage: two banks, each 16 entries of 8+d bits. Each bank has a status bit, EMPTY or FULL.
- Write side keeps wr_bank (1 bit) and wr_cnt (4 bits). Read side keeps rd_bank (1 bit) and rd_cnt (4 bits).
- Reset (rst_n=0, async):
  - both banks EMPTY; all counters 0; wr_bank = rd_bank = 0; storage cleared to 0
  - outputs: in_ready=1, out_valid=0, out_last=0, out_byte=0
- in_ready = (bank[wr_bank] EMPTY) and not clr.
- Input accept (in_valid & in_ready):
  - in_byte is written to entry wr_cnt of bank[wr_bank]; wr_cnt increments.
  - At wr_cnt=15, wr_cnt wraps to 0, bank[wr_bank] becomes FULL and wr_bank toggles.
- out_valid = bank[rd_bank] FULL.
- out_byte = bank[rd_bank] entry src(rd_cnt), driven combinationally from storage.
  - src(k): r = k mod 4, c = k div 4, src = 4*((c - r) mod 4) + r.
  - Resulting sequence: 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
- out_last = out_valid & (rd_cnt == 15).
- Output accept (out_valid & out_ready):
  - rd_cnt increments. At 15, rd_cnt wraps to 0, bank[rd_bank] becomes EMPTY and rd_bank toggles.
- Latency: the first output byte is valid in the cycle after the 16th input byte is accepted. No combinational path from in_* to out_*.
- Throughput: with continuous in_valid and out_ready, one byte per cycle sustained. in_ready never drops.
- Backpressure:
  - out_byte and out_last hold stable while out_valid & !out_ready; the bank is frozen until drained.
  - With both banks FULL, in_ready=0 until the read bank completes draining.
- Simultaneous completion:
  - The write side filling bank X and the read side emptying bank Y in the same cycle are independent; both status updates apply.
  - Same-bank FULL→EMPTY and EMPTY→FULL in one cycle is impossible by construction.
- in_valid low mid-block: wr_cnt holds and the partial block is retained. There is no timeout.
- clr:
  - Takes effect at the next edge; same register values as reset except storage is not cleared.
  - in_ready=0 during the clr cycle. Any in or out handshake in that cycle is dropped.
- rst_n asserted mid-block: all partial and full blocks are discarded immediately.
- Redundancy bits are carried verbatim. No checking or recomputation is done here.

Decomposition:
- Package aes_rb_pkg:
  - rb_byte_t = logic [0:7+d]
  - rb_state_t = [3:0][3:0] rb_byte_t (row, column)
  - constant NB_BYTES = 16
  - function inv_sr_src(k) returning the 4-bit source index
- One sub-module, inv_sr_bank: 16-entry register bank with write-enable/index and combinational read at inv_sr_src(rd_idx). The top level instantiates two and holds the handshake and bank-status control.

Test Plan:
- Reset, then stream in_byte = k (d bits 0), k=0..15, with out_ready=1 → out_byte sequence 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03. First out_valid is one cycle after the 16th accept; out_last only on the 0x03 byte.
- Back-to-back 4 blocks with random data, out_ready=1 → in_ready constantly 1; 64 outputs match the reference model; no bubbles after the first block.
- out_ready=0 while 32 bytes are offered → in_ready falls after exactly 32 accepts; out_byte stays at 00 and is stable. Releasing out_ready drains both blocks in order.
- Redundancy bits set to all-ones pattern with data k → redundancy bits are preserved per byte through the permutation.
- Pulse clr after 7 input bytes, then send a fresh block → output equals the fresh block only; no stale bytes appear.
- Assert rst_n=0 asynchronously mid-drain (rd_cnt=5) → out_valid drops immediately; after release in_ready=1 and the next block is correct.
